tdm_mux4: RTL and testbench

- 4-to-1 time-division multiplexer. It is the sending end that feeds the team's 1:4 demultiplexer.
- Four valid/ready source lanes are arbitrated round-robin onto one registered output channel.
- Each output beat carries the source lane code on `out_sel`. A downstream 1:4 demultiplexer drives its select from `out_sel` and routes the beat back to lane Y[`out_sel`].
- Sits between the lane producers and the serial link or demultiplexer.

---
 rtl/tdm_mux_pkg.sv | 14 +
 rtl/rr_arbiter4.sv | 43 ++++
 rtl/tdm_mux4.sv | 120 ++++++++++++
 tb/tb_tdm_mux4.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_mux_pkg.sv
// Shared lane count, lane-code type and round-robin helper for the 4:1 TDM multiplexer.
package tdm_mux_pkg;

  localparam int LANES = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] lane_sel_t;

  // The natural 2-bit wrap gives 3 -> 0.
  function automatic lane_sel_t rr_next(input lane_sel_t sel);
    return sel + lane_sel_t'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin scan over four requests, starting at lane ptr.
module rr_arbiter4
  import tdm_mux_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] grant,
  output logic [1:0] winner,
  output logic       any
);

  // rot_req[gi] is the request of the lane gi steps after ptr.
  logic [LANES-1:0] rot_req;
  lane_sel_t        win_off;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_rot
      lane_sel_t idx;
      assign idx         = ptr + lane_sel_t'(gi);
      assign rot_req[gi] = req[idx];
    end
  endgenerate

  always_comb begin
    win_off = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        win_off = lane_sel_t'(i);
      end
    end
  end

  assign any    = |req;
  assign winner = ptr + win_off;

  generate
    for (gi = 0; gi < LANES; gi++) begin : g_grant
      assign grant[gi] = any && (winner == lane_sel_t'(gi));
    end
  endgenerate

endmodule

// File: rtl/tdm_mux4.sv
// 4:1 round-robin TDM multiplexer with a registered output beat tagged by source lane.
// Define TDM_MUX_LOCK_EN to add in_last and hold the grant on a lane until its packet ends.
module tdm_mux4
  import tdm_mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            in_valid,
  input  logic [4*DATA_W-1:0]   in_data,
`ifdef TDM_MUX_LOCK_EN
  input  logic [3:0]            in_last,
`endif
  output logic [3:0]            in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_sel,
  input  logic                  out_ready
);

  logic                  out_valid_reg, out_valid_next;
  logic [DATA_W-1:0]     out_data_reg, out_data_next;
  lane_sel_t             out_sel_reg, out_sel_next;
  lane_sel_t             ptr_reg, ptr_next;
`ifdef TDM_MUX_LOCK_EN
  logic                  lock_reg, lock_next;
  lane_sel_t             lock_lane_reg, lock_lane_next;
`endif

  logic [DATA_W-1:0]     lane_data [LANES];
  logic [LANES-1:0]      req;
  logic [LANES-1:0]      grant;
  lane_sel_t             winner;
  logic                  any_req;
  logic                  slot_free;
  logic                  xfer;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_data[gi] = in_data[gi*DATA_W +: DATA_W];
`ifdef TDM_MUX_LOCK_EN
      // While a packet is open only its own lane may request.
      assign req[gi] = in_valid[gi] && (!lock_reg || (lock_lane_reg == lane_sel_t'(gi)));
`else
      assign req[gi] = in_valid[gi];
`endif
    end
  endgenerate

  rr_arbiter4 u_arb (
    .req    (req),
    .ptr    (ptr_reg),
    .grant  (grant),
    .winner (winner),
    .any    (any_req)
  );

  assign slot_free = !out_valid_reg || out_ready;
  assign in_ready  = grant & {LANES{slot_free && rst_n}};
  assign xfer      = any_req && slot_free && rst_n;

  always_comb begin
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_sel_next   = out_sel_reg;
    ptr_next       = ptr_reg;
`ifdef TDM_MUX_LOCK_EN
    lock_next      = lock_reg;
    lock_lane_next = lock_lane_reg;
`endif
    if (xfer) begin
      // A new beat overwrites a retiring one in the same cycle, so no bubble.
      out_valid_next = 1'b1;
      out_data_next  = lane_data[winner];
      out_sel_next   = winner;
`ifdef TDM_MUX_LOCK_EN
      if (in_last[winner]) begin
        lock_next = 1'b0;
        ptr_next  = rr_next(winner);
      end else begin
        lock_next      = 1'b1;
        lock_lane_next = winner;
      end
`else
      ptr_next = rr_next(winner);
`endif
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      ptr_reg       <= '0;
`ifdef TDM_MUX_LOCK_EN
      lock_reg      <= 1'b0;
      lock_lane_reg <= '0;
`endif
    end else begin
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_sel_reg   <= out_sel_next;
      ptr_reg       <= ptr_next;
`ifdef TDM_MUX_LOCK_EN
      lock_reg      <= lock_next;
      lock_lane_reg <= lock_lane_next;
`endif
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_tdm_mux4.sv
// Bench for tdm_mux4: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a lane-scan reference model.
module tb_tdm_mux4;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]    in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_sel;
  logic          out_ready;
`ifdef TDM_MUX_LOCK_EN
  logic [3:0]    in_last;
`endif

  int checks = 0;
  int errors = 0;

  tdm_mux4 #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef TDM_MUX_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Downstream 1:4 demultiplexer driven by out_sel, carrying out_data bit 0.
  logic [3:0] y;
  always_comb begin
    y = 4'b0000;
    if (out_valid) y[out_sel] = out_data[0];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_ptr   = 0;
  logic        m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  int          m_sel   = 0;
`ifdef TDM_MUX_LOCK_EN
  bit          m_lock  = 0;
  int          m_lock_lane = 0;
`endif

  function automatic logic [3:0] exp_ready();
    logic [3:0] r;
    r = 4'b0000;
    if (rst_n !== 1'b1) return r;
    if (m_valid && !out_ready) return r;
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (m_ptr + i) % 4;
`ifdef TDM_MUX_LOCK_EN
      if (m_lock && k != m_lock_lane) continue;
`endif
      if (in_valid[k]) begin
        r[k] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    logic [3:0] er;
    int k;
    if (rst_n !== 1'b1) begin
      m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
`ifdef TDM_MUX_LOCK_EN
      m_lock = 0;
`endif
    end else begin
      er = exp_ready();
      k = -1;
      for (int i = 0; i < 4; i++) if (er[i] && in_valid[i]) k = i;
      if (k >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[k*DW +: DW];
        m_sel   = k;
`ifdef TDM_MUX_LOCK_EN
        if (in_last[k]) begin
          m_lock = 0;
          m_ptr  = (k + 1) % 4;
        end else begin
          m_lock = 1;
          m_lock_lane = k;
        end
`else
        m_ptr = (k + 1) % 4;
`endif
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // One compare process: every cycle, half a period after the active edge.
  always @(negedge clk) begin
    chk("m_in_ready",  {28'd0, in_ready}, {28'd0, exp_ready()});
    chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("m_out_data",  {24'd0, out_data}, {24'd0, m_data});
    chk("m_out_sel",   {30'd0, out_sel}, m_sel);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  initial begin
    logic [3:0] ey;
    logic       ph;
    rst_n = 1'b0;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    set_lanes(8'hA0, 8'hA1, 8'hA2, 8'hA3);
`ifdef TDM_MUX_LOCK_EN
    in_last = 4'b1111;
`endif

    // 1. reset hold
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_in_ready", {28'd0, in_ready}, 32'h0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'h0);
      chk("rst_out_sel", {30'd0, out_sel}, 32'h0);
    end
    rst_n = 1'b1;
    #1;
    chk("first_grant", {28'd0, in_ready}, 32'h1);

    // 2. round robin
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rr_sel", {30'd0, out_sel}, i % 4);
      chk("rr_data", {24'd0, out_data}, 32'hA0 + (i % 4));
    end

    // 3. sparse request, wrap scan from ptr=3
    in_valid = 4'b0100;
    in_data[2*DW +: DW] = 8'h5C;
    cyc();
    chk("sparse_sel", {30'd0, out_sel}, 32'h2);
    chk("wrap_ready", {28'd0, in_ready}, 32'h4);
    cyc();
    chk("wrap_sel", {30'd0, out_sel}, 32'h2);
    chk("wrap_data", {24'd0, out_data}, 32'h5C);
    in_valid = 4'b0000;
    cyc();
    chk("retire_valid", {31'd0, out_valid}, 32'h0);
    chk("retire_hold", {22'd0, out_sel, out_data}, {22'd0, 2'd2, 8'h5C});

    // 4. back-pressure
    in_valid = 4'b1111;
    set_lanes(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    out_ready = 1'b0;
    cyc();
    chk("bp_first", {21'd0, out_valid, out_sel, out_data}, {21'd0, 1'b1, 2'd3, 8'hA3});
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_ready", {28'd0, in_ready}, 32'h0);
      chk("bp_hold", {21'd0, out_valid, out_sel, out_data}, {21'd0, 1'b1, 2'd3, 8'hA3});
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release", {28'd0, in_ready}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("bp_drain", {21'd0, out_valid, out_sel, out_data}, {21'd0, 1'b1, 2'(i), 8'(8'hA0 + i)});
    end

    // 5. loopback through the demultiplexer
    for (int i = 0; i < 8; i++) begin
      ph = (i % 2 == 0);
      set_lanes({7'd0, ph}, {7'd0, ph}, {7'd0, ph}, {7'd0, ph});
      cyc();
      ey = ph ? (4'b0001 << (i % 4)) : 4'b0000;
      chk("loop_y", {28'd0, y}, {28'd0, ey});
    end

`ifdef TDM_MUX_LOCK_EN
    // 6. packet lock
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    in_valid = 4'b0110;
    in_last = 4'b0000;
    cyc();
    chk("lock_b1", {30'd0, out_sel}, 32'h1);
    cyc();
    chk("lock_b2", {30'd0, out_sel}, 32'h1);
    in_last = 4'b0010;
    cyc();
    chk("lock_b3", {30'd0, out_sel}, 32'h1);
    in_last = 4'b0000;
    cyc();
    chk("lock_next", {30'd0, out_sel}, 32'h2);
    in_valid = 4'b0011;
    #1;
    chk("lock_block", {28'd0, in_ready}, 32'h0);
    rst_n = 1'b0;
    cyc();
    chk("lock_rst", {27'd0, in_ready, out_valid}, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("lock_clear", {28'd0, in_ready}, 32'h1);
    cyc();
    chk("lock_lane0", {30'd0, out_sel}, 32'h0);
`endif

    // randomized traffic, checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef TDM_MUX_LOCK_EN
      in_last   = 4'($urandom);
`endif
      cyc();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
